func_root_gen: RTL and testbench

- Parametrised successor of the team's single-function root evaluator.
- Computes y = floor(sqrt(a + floor(cbrt(b)))) in mode 0, or y = floor(cbrt(a + floor(sqrt(b)))) in mode 1.
- Operands are WIDTH bits. Both roots are computed by internal digit-by-digit iterative engines; there are no external sqrt, mult or adder instances.
- Sits as a start/busy/done coprocessor next to the existing func blocks, with a deterministic, data-independent latency.

---
 rtl/func_root_gen.sv | 161 ++++++++++++++++
 tb/tb_func_root_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/func_root_gen.sv
// func_root_gen: two-stage root coprocessor with start/busy/done handshake.
//   mode 0: y = floor(sqrt(a + floor(cbrt(b))))
//   mode 1: y = floor(cbrt(a + floor(sqrt(b))))
// Both roots share one digit-by-digit engine (x = remainder, y = partial root).
// The engine does one iteration per cycle. Latency is fixed by WIDTH and mode only.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-low reset
//   a_bi     operand a, sampled when a start is accepted
//   b_bi     operand b, sampled when a start is accepted
//   mode_i   function select, sampled when a start is accepted
//   start_i  request, honoured only in IDLE
//   busy_o   operation in flight
//   done_o   one-cycle pulse when y_bo is updated
//   y_bo     result, held until the next completion
module func_root_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned YW    = (WIDTH + 2) / 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_bi,
    input  logic [WIDTH-1:0] b_bi,
    input  logic             mode_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [YW-1:0]    y_bo
);

    // SW holds a + root without overflow. BW is wide enough for any shifted
    // subtrahend, so the trial value never truncates.
    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned BW = SW + 4;

    // Starting iteration index (iterations - 1) for each root and operand size
    localparam logic [4:0] ItCbB = 5'((WIDTH + 2) / 3 - 1);
    localparam logic [4:0] ItSqB = 5'((WIDTH + 1) / 2 - 1);
    localparam logic [4:0] ItSqS = 5'((SW + 1) / 2 - 1);
    localparam logic [4:0] ItCbS = 5'((SW + 2) / 3 - 1);

    typedef enum logic [1:0] {StIdle, StRoot1, StSum, StRoot2} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             mode_q, mode_d;
    logic [SW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [YW-1:0]    y_out_q, y_out_d;

    logic             cbrt_sel;
    logic [5:0]       sh;
    logic [YW-1:0]    y_sh;
    logic [BW-1:0]    y_ext;
    logic [BW-1:0]    bb;
    logic             take;
    logic [SW-1:0]    x_it;
    logic [YW-1:0]    y_it;

    // One engine iteration, for whichever root the current stage needs
    always_comb begin
        cbrt_sel = (state_q == StRoot1) ? ~mode_q : mode_q;
        sh       = cbrt_sel ? 6'(cnt_q) * 6'd3 : {cnt_q, 1'b0};
        y_sh     = {y_q[YW-2:0], 1'b0};
        y_ext    = BW'(y_sh);
        if (cbrt_sel) begin
            // (y+1)^3 - y^3 = 3y(y+1) + 1
            bb = (BW'(3) * y_ext * (y_ext + BW'(1)) + BW'(1)) << sh;
        end else begin
            // (y+1)^2 - y^2 = 2y + 1
            bb = ((y_ext << 1) + BW'(1)) << sh;
        end
        take = (BW'(x_q) >= bb);
        x_it = take ? x_q - bb[SW-1:0] : x_q;
        y_it = take ? (y_sh | YW'(1)) : y_sh;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        y_out_d = y_out_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d     = a_bi;
                    mode_d  = mode_i;
                    x_d     = {1'b0, b_bi};
                    y_d     = '0;
                    cnt_d   = mode_i ? ItSqB : ItCbB;
                    busy_d  = 1'b1;
                    state_d = StRoot1;
                end
            end
            StRoot1: begin
                x_d   = x_it;
                y_d   = y_it;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = StSum;
                end
            end
            StSum: begin
                // y_q holds the first root here
                x_d     = {1'b0, a_q} + SW'(y_q);
                y_d     = '0;
                cnt_d   = mode_q ? ItCbS : ItSqS;
                state_d = StRoot2;
            end
            StRoot2: begin
                x_d   = x_it;
                y_d   = y_it;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    y_out_d = y_it;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_out_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_out_q <= y_out_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign y_bo   = y_out_q;

endmodule

// File: tb/tb_func_root_gen.sv
// Bench for func_root_gen: an 8-bit and a 16-bit instance share clock and reset.
// Expected results are queued per instance at each accepted start and are
// popped by a monitor when done_o pulses.
module tb_func_root_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        mode8 = 1'b0, start8 = 1'b0;
    logic        busy8, done8;
    logic [4:0]  y8;
    logic [15:0] a16 = '0, b16 = '0;
    logic        mode16 = 1'b0, start16 = 1'b0;
    logic        busy16, done16;
    logic [8:0]  y16;

    int errors = 0;
    int checks = 0;
    int q8[$];
    int q16[$];
    int last8 = 0;

    always #5 clk = ~clk;

    func_root_gen #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst_n), .a_bi(a8), .b_bi(b8), .mode_i(mode8),
        .start_i(start8), .busy_o(busy8), .done_o(done8), .y_bo(y8)
    );

    func_root_gen #(.WIDTH(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst_n), .a_bi(a16), .b_bi(b16), .mode_i(mode16),
        .start_i(start16), .busy_o(busy16), .done_o(done16), .y_bo(y16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int icbrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int ref_y(input int a, input int b, input bit m);
        return m ? icbrt(a + isqrt(b)) : isqrt(a + icbrt(b));
    endfunction

    function automatic int ref_lat(input int w, input bit m);
        return m ? (w + 1) / 2 + (w + 3) / 3 + 1 : (w + 2) / 3 + (w + 2) / 2 + 1;
    endfunction

    // Scoreboard side: every done pulse must match the oldest queued result
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) check("done8_unexpected", done8, 0);
            else check("y8", y8, q8.pop_front());
        end
        if (done16) begin
            if (q16.size() == 0) check("done16_unexpected", done16, 0);
            else check("y16", y16, q16.pop_front());
        end
    end

    task automatic start_op(input bit wide, input int a, input int b, input bit m);
        @(negedge clk);
        if (wide) begin
            a16 = 16'(a); b16 = 16'(b); mode16 = m; start16 = 1'b1;
        end else begin
            a8 = 8'(a); b8 = 8'(b); mode8 = m; start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8 = 1'b0;
        start16 = 1'b0;
        if (wide) q16.push_back(ref_y(a, b, m));
        else begin
            q8.push_back(ref_y(a, b, m));
            last8 = ref_y(a, b, m);
        end
    endtask

    // Counts cycles to done, checks busy across the operation; optionally
    // pulses a competing start on the 8-bit instance at cycle inject_at.
    task automatic wait_done(input bit wide, input int exp_lat, input string tag,
                             input int inject_at);
        int  n = 0;
        bit  dn = 1'b0;
        bit  busy_ok = 1'b1;
        while (!dn && n < 40) begin
            @(negedge clk);
            n++;
            if (inject_at != 0 && n == inject_at) begin
                a8 = 8'd200; b8 = 8'd3; mode8 = ~mode8; start8 = 1'b1;
            end
            if (inject_at != 0 && n == inject_at + 1) start8 = 1'b0;
            dn = wide ? done16 : done8;
            if (!dn && !(wide ? busy16 : busy8)) busy_ok = 1'b0;
        end
        check({tag, "_lat"}, n - 1, exp_lat);
        check({tag, "_busy_at_done"}, wide ? busy16 : busy8, 0);
        check({tag, "_busy_during"}, busy_ok, 1);
    endtask

    task automatic run(input bit wide, input int a, input int b, input bit m, input string tag);
        start_op(wide, a, b, m);
        wait_done(wide, ref_lat(wide ? 16 : 8, m), tag, 0);
    endtask

    initial begin
        bit seen;
        #2;
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_y8", y8, 0);
        check("rst_y16", y16, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(0, 10, 27, 0, "m0_10_27");
        run(0, 255, 255, 0, "m0_max");
        run(0, 0, 0, 0, "m0_zero");
        run(0, 255, 255, 1, "m1_max");
        run(0, 0, 64, 1, "m1_0_64");
        run(0, 0, 0, 1, "m1_zero");

        // Result holds while idle
        repeat (3) @(negedge clk);
        check("hold_y8", y8, last8);

        // Competing start three cycles in must be ignored
        start_op(0, 100, 200, 0);
        wait_done(0, ref_lat(8, 0), "ignored_start", 3);
        repeat (12) @(negedge clk);

        // Asynchronous reset four cycles into an operation
        run(0, 250, 250, 1, "pre_rst");
        start_op(0, 200, 100, 0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy8", busy8, 0);
        check("abort_y8", y8, 0);
        q8.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        check("abort_no_activity", seen, 0);
        run(0, 10, 27, 0, "post_rst");

        run(1, 65535, 65535, 0, "w16_m0_max");
        run(1, 65535, 65535, 1, "w16_m1_max");
        run(1, 0, 0, 0, "w16_zero");

        for (int i = 0; i < 24; i++) begin
            run(i[0], int'($urandom_range(0, i[0] ? 65535 : 255)),
                int'($urandom_range(0, i[0] ? 65535 : 255)), i[1], "rand");
        end

        repeat (3) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q16_drained", q16.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
